// File: rtl/dm_bus_arbiter_if.sv
// Shared data-memory port bundle: two requester channels plus the arbitrated memory side.
// The slave modport is the arbiter's view; master is the requesters/memory view.
interface dm_bus_arbiter_if;
  logic        r0_req;
  logic [31:0] r0_addr;
  logic [31:0] r0_wdata;
  logic [3:0]  r0_byteen;
  logic        r0_gnt;
  logic        r0_rvalid;
  logic [31:0] r0_rdata;

  logic        r1_req;
  logic [31:0] r1_addr;
  logic [31:0] r1_wdata;
  logic [3:0]  r1_byteen;
  logic        r1_gnt;
  logic        r1_rvalid;
  logic [31:0] r1_rdata;

  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_rdata;

  modport slave (
    input  r0_req, r0_addr, r0_wdata, r0_byteen,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_addr, r1_wdata, r1_byteen,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_en, mem_addr, mem_wdata, mem_byteen,
    input  mem_rdata
  );

  modport master (
    output r0_req, r0_addr, r0_wdata, r0_byteen,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_addr, r1_wdata, r1_byteen,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_en, mem_addr, mem_wdata, mem_byteen,
    output mem_rdata
  );
endinterface

// File: rtl/dm_bus_arbiter.sv
// Two-requester arbiter for the shared DM/Bridge port: fixed priority to r0 with a
// starvation guard for r1, and read-owner tracking across the synchronous RAM latency.
module dm_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned RD_LAT       = 1
) (
  input logic             clk,
  input logic             sys_rstn,
  dm_bus_arbiter_if.slave bus
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [3:0]        starve_q, starve_d;
  logic              force_r1, r0_win, r1_win, push;
  logic [RD_LAT-1:0] vld_q, vld_d, own_q, own_d;

  // Grants are gated by reset so nothing reaches the port while sys_rstn is low.
  always_comb begin
    force_r1 = bus.r1_req && (starve_q == Limit);
    r1_win   = sys_rstn && bus.r1_req && (force_r1 || !bus.r0_req);
    r0_win   = sys_rstn && bus.r0_req && !force_r1;
  end

  assign bus.r0_gnt = r0_win;
  assign bus.r1_gnt = r1_win;
  assign bus.mem_en = r0_win | r1_win;

  always_comb begin
    bus.mem_addr   = 32'h0;
    bus.mem_wdata  = 32'h0;
    bus.mem_byteen = 4'h0;
    if (r0_win) begin
      bus.mem_addr   = bus.r0_addr;
      bus.mem_wdata  = bus.r0_wdata;
      bus.mem_byteen = bus.r0_byteen;
    end else if (r1_win) begin
      bus.mem_addr   = bus.r1_addr;
      bus.mem_wdata  = bus.r1_wdata;
      bus.mem_byteen = bus.r1_byteen;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (r1_win || !bus.r1_req) begin
      starve_d = 4'h0;
    end else if (r0_win && (starve_q < Limit)) begin
      starve_d = starve_q + 4'h1;
    end
  end

  // Stage 0 takes the issuing access; the tail stage lines up with mem_rdata.
  always_comb begin
    push     = (r0_win | r1_win) && (bus.mem_byteen == 4'h0);
    vld_d    = vld_q;
    own_d    = own_q;
    vld_d[0] = push;
    own_d[0] = r1_win;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      starve_q <= 4'h0;
      vld_q    <= '0;
      own_q    <= '0;
    end else begin
      starve_q <= starve_d;
      vld_q    <= vld_d;
      own_q    <= own_d;
    end
  end

  assign bus.r0_rvalid = vld_q[RD_LAT-1] && !own_q[RD_LAT-1];
  assign bus.r1_rvalid = vld_q[RD_LAT-1] &&  own_q[RD_LAT-1];
  assign bus.r0_rdata  = bus.r0_rvalid ? bus.mem_rdata : 32'h0;
  assign bus.r1_rdata  = bus.r1_rvalid ? bus.mem_rdata : 32'h0;

endmodule

// File: doc/dm_bus_arbiter.md
Name: dm_bus_arbiter

Overview:
- Shares the single data-memory/Bridge port (DM block RAM plus memory-mapped peripherals) between two requesters.
- Requester 0 is the CPU M-stage data port. Requester 1 is a secondary master, e.g. a future UART receive-DMA engine.
- Fixed priority to requester 0, with a starvation guard that forces a grant to requester 1 after a bounded wait.
- Tracks outstanding reads so read data returns to the requester that issued it, after the synchronous RAM latency.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles r1 may be refused while requesting before it is forced to win; legal range 1..15.
- RD_LAT, 1: cycles from accepted read to valid mem_rdata; legal range 1..4.

Ports:
- clk  input  1  system clock (cpu_clk domain)
- sys_rstn  input  1  asynchronous active-low reset
- r0_req  input  1  CPU access request
- r0_addr  input  32  CPU byte address
- r0_wdata  input  32  CPU write data
- r0_byteen  input  4  CPU byte enables; 4'b0000 means read
- r0_gnt  output  1  CPU request accepted this cycle
- r0_rvalid  output  1  CPU read data valid
- r0_rdata  output  32  CPU read data
- r1_req  input  1  secondary master request
- r1_addr  input  32  secondary master byte address
- r1_wdata  input  32  secondary master write data
- r1_byteen  input  4  secondary master byte enables; 0 means read
- r1_gnt  output  1  secondary request accepted this cycle
- r1_rvalid  output  1  secondary read data valid
- r1_rdata  output  32  secondary read data
- mem_en  output  1  access issued to shared port this cycle
- mem_addr  output  32  shared port address
- mem_wdata  output  32  shared port write data
- mem_byteen  output  4  shared port byte enables; forced 0 when mem_en=0
- mem_rdata  input  32  shared port read data, valid RD_LAT cycles after issue

Behaviour:
- Clock and reset: one clock, clk. Reset sys_rstn is asynchronous and active-low.
- Arbitration is combinational in the request cycle. A requester holds req, addr, wdata and byteen stable until it sees gnt in the same cycle.
- At most one gnt per cycle. mem_en = r0_gnt | r1_gnt. mem_addr, mem_wdata and mem_byteen are muxed from the winner. With no grant, mem_addr and mem_wdata = 0 and mem_byteen = 0.
- Priority rule:
  - starve_cnt is a 4-bit register.
  - If r1_req and starve_cnt == STARVE_LIMIT, then r1 wins.
  - Otherwise r0 wins if r0_req, else r1 wins if r1_req.
- starve_cnt update, every clock edge:
  - clears to 0 when r1_gnt or !r1_req;
  - increments when r1_req and r0_gnt;
  - saturates at STARVE_LIMIT and never wraps.
- Read tracking:
  - An RD_LAT-deep shift pipeline of {valid, owner} entries.
  - A granted access with byteen == 0 pushes {1, winner} at the issuing edge. Every other cycle pushes {0, x}.
  - At the pipeline tail, rX_rvalid = valid && owner == X. Both rvalid outputs are registered signals, asserted exactly RD_LAT cycles after the gnt cycle.
  - rX_rdata = mem_rdata when rX_rvalid, else 0.
- Writes (byteen != 0) never produce rvalid. A write may be issued back-to-back with, or while, a read is in flight. Pipeline issue throughput is one access per cycle.
- Back-to-back reads from alternating owners return in issue order, one per cycle, with no bubbles.
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream):
  - starve_cnt = 0 and the pipeline is cleared, so r0_rvalid = r1_rvalid = 0.
  - While sys_rstn = 0, r0_gnt = r1_gnt = 0, mem_en = 0 and mem_byteen = 0, regardless of req.
- Reset mid-read: the in-flight read is dropped and no rvalid is ever produced for it.
- Requests deasserted without a gnt are simply withdrawn; no state changes except the starve_cnt clear.

Test Plan:
- Reset, then r0_req=1 with addr 0x0000_0010 and byteen 0 → r0_gnt same cycle, mem_addr=0x10, mem_byteen=0. One cycle later r0_rvalid=1 and r0_rdata = mem_rdata (model returns 0xDEAD_BEEF). r1_rvalid stays 0.
- r0 and r1 both request continuously, STARVE_LIMIT=4 → grants are r0,r0,r0,r0,r1,r0,r0,r0,r0,r1,…; starve_cnt never exceeds 4.
- r1 write alone (addr 0x0000_7F00, wdata 0x0000_00FF, byteen 4'b0001) → r1_gnt same cycle, mem_byteen=4'b0001, mem_wdata=0xFF, no rvalid on either port.
- Alternating reads r0(0x20), r1(0x24), r0(0x28) with RD_LAT=2 → rvalid sequence r0,r1,r0 on consecutive cycles starting 2 cycles after the first gnt, each carrying the model's per-address data.
- r0 read granted, then sys_rstn pulled low for 1 cycle before data returns → no r0_rvalid afterwards; gnt, mem_en and mem_byteen are 0 during reset.
- r1_req held 3 cycles under r0 contention, dropped 1 cycle, then reasserted → starve_cnt restarts at 0; r1 waits a full 4 refusals before being forced through.
